// File: rtl/step_dir_decoder_pkg.sv
// Shared encodings for the step/dir receive path: decoder states and the
// direction polarity used by the step generator's drv_dir line.
package step_dir_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRACKING = 2'd2
    } dec_state_t;

    localparam logic DIR_POS = 1'b1;
    localparam logic DIR_NEG = 1'b0;

endpackage

// File: rtl/step_dir_decoder_sync_edge_det.sv
// Multi-flop synchroniser for an asynchronous line, with a one-cycle pulse
// on each rising edge of the synchronised level.
module sync_edge_det #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic sync,
    output logic rise
);

    logic [STAGES-1:0] chain_r;
    logic              prev_r;

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_r <= '0;
            prev_r  <= 1'b0;
        end else begin
            chain_r <= {chain_r[STAGES-2:0], d};
            prev_r  <= chain_r[STAGES-1];
        end
    end

    assign sync = chain_r[STAGES-1];
    assign rise = chain_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/step_dir_decoder.sv
// Receive side of the step/dir interface: signed position tracking, step
// period measurement, stall detection and sticky overspeed/dir-setup flags.
module step_dir_decoder
    import step_dir_decoder_pkg::*;
#(
    parameter int POS_WIDTH     = 24,
    parameter int PERIOD_WIDTH  = 20,
    parameter int SYNC_STAGES   = 2,
    parameter int MIN_PERIOD    = 50,
    parameter int DIR_SETUP     = 4,
    parameter int STALL_TIMEOUT = 500000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    step_in,
    input  logic                    dir_in,
    input  logic                    clear_pos,
    input  logic                    err_clear,
    output logic [POS_WIDTH-1:0]    position,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    moving,
    output logic                    err_overspeed,
    output logic                    err_dir_setup
);

    localparam int                      DS_W      = $clog2(DIR_SETUP + 1);
    localparam logic [PERIOD_WIDTH-1:0] CNT_MAX   = {PERIOD_WIDTH{1'b1}};
    localparam logic [PERIOD_WIDTH-1:0] STALL_LIM = PERIOD_WIDTH'(STALL_TIMEOUT - 1);
    localparam logic [PERIOD_WIDTH-1:0] MIN_P     = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [DS_W-1:0]         DS_MAX    = DS_W'(DIR_SETUP);
    localparam logic [POS_WIDTH-1:0]    POS_ONE   = POS_WIDTH'(1);

    function automatic logic [PERIOD_WIDTH-1:0] cnt_inc(input logic [PERIOD_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            cnt_inc = CNT_MAX;
        end else begin
            cnt_inc = v + PERIOD_WIDTH'(1);
        end
    endfunction

    logic step_rise_s, step_sync_unused_s;
    logic dir_sync_s, dir_rise_unused_s;

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_step_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (step_in),
        .sync (step_sync_unused_s),
        .rise (step_rise_s)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES)) u_dir_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (dir_in),
        .sync (dir_sync_s),
        .rise (dir_rise_unused_s)
    );

    dec_state_t              state_r, state_s, state_nxt_s;
    logic [PERIOD_WIDTH-1:0] cnt_r, cnt_s, cnt_nxt_s, meas_s;
    logic [PERIOD_WIDTH-1:0] period_r, period_s;
    logic                    pv_r, pv_s, moving_r, moving_s;
    logic [POS_WIDTH-1:0]    position_r, pos_s, pos_base_s;
    logic                    dir_last_r;
    logic [DS_W-1:0]         dir_stable_r, dir_stable_s, dir_eff_s;
    logic                    err_os_r, err_os_s, err_ds_r, err_ds_s;
    logic                    count_step_s, os_event_s, ds_event_s;

    // FSM next state and period measurement; enable low always forces IDLE.
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        period_s     = period_r;
        pv_s         = 1'b0;
        os_event_s   = 1'b0;
        meas_s       = cnt_inc(cnt_r);
        count_step_s = step_rise_s && (state_r != ST_IDLE);
        case (state_r)
            ST_IDLE: begin
                cnt_nxt_s   = '0;
                state_nxt_s = ST_ARMED;
            end
            ST_ARMED: begin
                cnt_nxt_s = '0;
                if (step_rise_s) begin
                    state_nxt_s = ST_TRACKING;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_TRACKING: begin
                if (step_rise_s) begin
                    period_s   = meas_s;
                    pv_s       = 1'b1;
                    os_event_s = (meas_s < MIN_P);
                    cnt_nxt_s  = '0;
                end else if (cnt_r >= STALL_LIM) begin
                    state_nxt_s = ST_ARMED;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = meas_s;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = '0;
            end
        endcase
        if (!enable) begin
            state_s = ST_IDLE;
            cnt_s   = '0;
        end else begin
            state_s = state_nxt_s;
            cnt_s   = cnt_nxt_s;
        end
        moving_s = (state_s == ST_TRACKING);
    end

    // Position update, dir stability tracking and sticky error flags.
    always_comb begin
        if (dir_sync_s != dir_last_r) begin
            dir_eff_s = '0;
        end else begin
            dir_eff_s = dir_stable_r;
        end
        if (dir_eff_s == DS_MAX) begin
            dir_stable_s = DS_MAX;
        end else begin
            dir_stable_s = dir_eff_s + DS_W'(1);
        end
        ds_event_s = count_step_s && (dir_eff_s < DS_MAX);
        if (clear_pos) begin
            pos_base_s = '0;
        end else begin
            pos_base_s = position_r;
        end
        pos_s = pos_base_s;
        if (count_step_s) begin
            case (dir_sync_s)
                DIR_POS: pos_s = pos_base_s + POS_ONE;
                DIR_NEG: pos_s = pos_base_s - POS_ONE;
                default: pos_s = pos_base_s;
            endcase
        end else begin
            pos_s = pos_base_s;
        end
        err_os_s = os_event_s | (err_os_r & ~err_clear);
        err_ds_s = ds_event_s | (err_ds_r & ~err_clear);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            period_r     <= '0;
            pv_r         <= 1'b0;
            moving_r     <= 1'b0;
            position_r   <= '0;
            dir_last_r   <= 1'b0;
            dir_stable_r <= '0;
            err_os_r     <= 1'b0;
            err_ds_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            period_r     <= period_s;
            pv_r         <= pv_s;
            moving_r     <= moving_s;
            position_r   <= pos_s;
            dir_last_r   <= dir_sync_s;
            dir_stable_r <= dir_stable_s;
            err_os_r     <= err_os_s;
            err_ds_r     <= err_ds_s;
        end
    end

    assign position      = position_r;
    assign period        = period_r;
    assign period_valid  = pv_r;
    assign moving        = moving_r;
    assign err_overspeed = err_os_r;
    assign err_dir_setup = err_ds_r;

endmodule
